// File: rtl/cpu_phase_ctrl_if.sv
// Handshake bundle between the phase sequencer and the register datapath.
// master drives enable/opcode/zero, slave (the sequencer) returns strobes.
interface cpu_phase_ctrl_if #(
    parameter int OPW = 3,
    parameter int PHW = 3
);
    logic           en;
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           sel;
    logic           rd;
    logic           ld_ir;
    logic           inc_pc;
    logic           ld_pc;
    logic           ld_ac;
    logic           wr;
    logic           data_e;
    logic           halt;
    logic [PHW-1:0] phase;

    modport master (
        output en, opcode, zero,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );

    modport slave (
        input  en, opcode, zero,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );
endinterface

// File: rtl/cpu_phase_ctrl.sv
// Eight-phase sequencer for the teaching CPU: steps a phase counter and decodes
// phase/opcode/zero into datapath strobes; HLT freezes the sequence until reset.
module cpu_phase_ctrl #(
    parameter int OPW = 3,
    parameter int PHW = 3
) (
    input  logic             clk,
    input  logic             rst,
    cpu_phase_ctrl_if.slave  bus
);
    // phase | meaning
    // 0 inst_addr | 1 inst_fetch | 2 inst_load | 3 idle
    // 4 op_addr   | 5 op_fetch   | 6 alu_op    | 7 store
    logic [PHW-1:0] phase_q;
    logic           halted_q;
    logic           is_hlt, is_skz, is_jmp, is_sto, is_aluop;

    always_comb begin
        is_hlt   = 1'b0;
        is_skz   = 1'b0;
        is_jmp   = 1'b0;
        is_sto   = 1'b0;
        is_aluop = 1'b0;
        // unknown opcodes fall through to default so nothing is decoded
        case (bus.opcode)
            OPW'(0): is_hlt   = 1'b1;
            OPW'(1): is_skz   = 1'b1;
            OPW'(2),
            OPW'(3),
            OPW'(4),
            OPW'(5): is_aluop = 1'b1;
            OPW'(6): is_sto   = 1'b1;
            OPW'(7): is_jmp   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= '0;
            halted_q <= 1'b0;
        end else if (!halted_q && bus.en) begin
            if (phase_q == PHW'(4) && is_hlt)
                halted_q <= 1'b1;
            else
                phase_q <= phase_q + 1'b1;
        end
    end

    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.wr     = 1'b0;
        bus.data_e = 1'b0;
        bus.halt   = halted_q;
        if (!halted_q) begin
            case (phase_q)
                3'd0: bus.sel = 1'b1;
                3'd1: begin
                    bus.sel = 1'b1;
                    bus.rd  = 1'b1;
                end
                3'd2, 3'd3: begin
                    bus.sel   = 1'b1;
                    bus.rd    = 1'b1;
                    bus.ld_ir = 1'b1;
                end
                3'd4: begin
                    bus.inc_pc = 1'b1;
                    bus.halt   = is_hlt;
                end
                3'd5: bus.rd = is_aluop;
                3'd6: begin
                    bus.rd     = is_aluop;
                    bus.inc_pc = is_skz && bus.zero;
                    bus.ld_pc  = is_jmp;
                    bus.data_e = is_sto;
                end
                3'd7: begin
                    bus.rd     = is_aluop;
                    bus.inc_pc = is_jmp;
                    bus.ld_pc  = is_jmp;
                    bus.ld_ac  = is_aluop;
                    bus.wr     = is_sto;
                    bus.data_e = is_sto;
                end
                default: ;
            endcase
        end
        // during a stall only the state-changing strobes drop; the bus stays put
        if (!bus.en) begin
            bus.ld_ir  = 1'b0;
            bus.inc_pc = 1'b0;
            bus.ld_pc  = 1'b0;
            bus.ld_ac  = 1'b0;
            bus.wr     = 1'b0;
        end
    end

    assign bus.phase = phase_q;
endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Directed-vector bench for cpu_phase_ctrl with a queue-based scoreboard.
// Strobe vector bit order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt.
module tb_cpu_phase_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_phase_ctrl_if #(.OPW(3), .PHW(3)) bus ();
    cpu_phase_ctrl #(.OPW(3), .PHW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    localparam logic [8:0] S_NONE  = 9'b000000000;
    localparam logic [8:0] S_PH0   = 9'b100000000;
    localparam logic [8:0] S_FETCH = 9'b110000000;
    localparam logic [8:0] S_LOAD  = 9'b111000000;
    localparam logic [8:0] S_OPADR = 9'b000100000;
    localparam logic [8:0] S_RD    = 9'b010000000;
    localparam logic [8:0] S_RDLD  = 9'b010001000;
    localparam logic [8:0] S_HALT  = 9'b000000001;

    typedef struct {
        string      name;
        logic [2:0] ph;
        logic [8:0] s;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [8:0] mon_got;
    int         n_vec = 0;
    int         n_bad = 0;
    string      cur_name = "init";

    // monitor: every cycle the sequencer presents a strobe set; compare mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_got = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                       bus.ld_ac, bus.wr, bus.data_e, bus.halt};
            n_vec++;
            if (mon_got !== mon_e.s || bus.phase !== mon_e.ph) begin
                n_bad++;
                $display("FAIL %s vec %0d: got phase=%0d strobes=%b, expected phase=%0d strobes=%b",
                         mon_e.name, n_vec, bus.phase, mon_got, mon_e.ph, mon_e.s);
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic [2:0] op,
                        input logic z, input logic [2:0] ph, input logic [8:0] s);
        exp_t x;
        rst        = r;
        bus.en     = e;
        bus.opcode = op;
        bus.zero   = z;
        x.name = cur_name;
        x.ph   = ph;
        x.s    = s;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // one full instruction; opcode/zero are garbage before ph3 to show they are ignored
    task automatic run_pass(input string nm, input logic [2:0] op, input logic z,
                            input logic [8:0] p5, input logic [8:0] p6, input logic [8:0] p7);
        cur_name = nm;
        step(0, 1, 3'd0, ~z, 3'd0, S_PH0);
        step(0, 1, 3'd0, ~z, 3'd1, S_FETCH);
        step(0, 1, 3'd0, ~z, 3'd2, S_LOAD);
        step(0, 1, op,   z,  3'd3, S_LOAD);
        step(0, 1, op,   z,  3'd4, S_OPADR);
        step(0, 1, op,   z,  3'd5, p5);
        step(0, 1, op,   z,  3'd6, p6);
        step(0, 1, op,   z,  3'd7, p7);
    endtask

    initial begin
        rst        = 1'b1;
        bus.en     = 1'b1;
        bus.opcode = 3'd0;
        bus.zero   = 1'b0;
        @(posedge clk);
        #1;
        cur_name = "reset";
        step(1, 1, 3'd0, 1'b0, 3'd0, S_PH0);

        run_pass("lda",  3'd5, 1'b0, S_RD,   S_RD,         S_RDLD);
        run_pass("sto",  3'd6, 1'b0, S_NONE, 9'b000000010, 9'b000000110);
        run_pass("skz1", 3'd1, 1'b1, S_NONE, S_OPADR,      S_NONE);
        run_pass("skz0", 3'd1, 1'b0, S_NONE, S_NONE,       S_NONE);
        run_pass("jmp",  3'd7, 1'b1, S_NONE, 9'b000010000, 9'b000110000);
        run_pass("add",  3'd2, 1'b1, S_RD,   S_RD,         S_RDLD);

        cur_name = "sto_stall";
        step(0, 1, 3'd6, 1'b0, 3'd0, S_PH0);
        step(0, 1, 3'd6, 1'b0, 3'd1, S_FETCH);
        step(0, 1, 3'd6, 1'b0, 3'd2, S_LOAD);
        step(0, 1, 3'd6, 1'b0, 3'd3, S_LOAD);
        step(0, 0, 3'd6, 1'b0, 3'd4, S_NONE);
        step(0, 1, 3'd6, 1'b0, 3'd4, S_OPADR);
        step(0, 1, 3'd6, 1'b0, 3'd5, S_NONE);
        step(0, 1, 3'd6, 1'b0, 3'd6, 9'b000000010);
        step(0, 0, 3'd6, 1'b0, 3'd7, 9'b000000010);
        step(0, 1, 3'd6, 1'b0, 3'd7, 9'b000000110);

        cur_name = "stall";
        step(0, 1, 3'd5, 1'b0, 3'd0, S_PH0);
        step(0, 1, 3'd5, 1'b0, 3'd1, S_FETCH);
        for (int i = 0; i < 3; i++)
            step(0, 0, 3'd5, 1'b0, 3'd2, S_FETCH);
        step(0, 1, 3'd5, 1'b0, 3'd2, S_LOAD);
        step(0, 1, 3'd5, 1'b0, 3'd3, S_LOAD);
        step(0, 1, 3'd5, 1'b0, 3'd4, S_OPADR);
        step(0, 1, 3'd5, 1'b0, 3'd5, S_RD);
        cur_name = "rst_mid";
        step(1, 1, 3'd5, 1'b0, 3'd6, S_RD);
        step(0, 1, 3'd5, 1'b0, 3'd0, S_PH0);

        cur_name = "halt";
        step(0, 1, 3'd0, 1'b0, 3'd1, S_FETCH);
        step(0, 1, 3'd0, 1'b0, 3'd2, S_LOAD);
        step(0, 1, 3'd0, 1'b0, 3'd3, S_LOAD);
        step(0, 0, 3'd0, 1'b0, 3'd4, S_HALT);
        step(0, 1, 3'd0, 1'b0, 3'd4, 9'b000100001);
        for (int i = 0; i < 20; i++)
            step(0, logic'(i % 2), 3'(i), logic'(i % 3 == 0), 3'd4, S_HALT);
        cur_name = "halt_rst";
        step(1, 1, 3'd0, 1'b0, 3'd4, S_HALT);
        step(0, 1, 3'd5, 1'b0, 3'd0, S_PH0);
        step(0, 1, 3'd5, 1'b0, 3'd1, S_FETCH);

        for (int i = 0; i < 4 && sb_q.size() > 0; i++)
            @(negedge clk);
        if (sb_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending vectors, expected 0", sb_q.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
